// File: rtl/h2c_dsc_pkg.sv
// Shared constants and FSM encoding for the H2C descriptor-bypass controller.
// Holds the XDMA stream beat geometry and the bypass control word.
package h2c_dsc_pkg;

  localparam int unsigned BEAT_BITS  = 256;
  localparam int unsigned BEAT_BYTES = BEAT_BITS / 8;

  // Bypass descriptor control word with only the EOP flag set.
  localparam logic [15:0] CTL_EOP = 16'h0010;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/h2c_dsc_bypass_ctrl.sv
// Issues one XDMA H2C bypass descriptor per host ring slot and tracks slot
// completion on the returning stream, which passes through unregistered.
module h2c_dsc_bypass_ctrl
  import h2c_dsc_pkg::*;
#(
  parameter logic [63:0] RING_BASE       = 64'h1_0000_0000,
  parameter int unsigned RING_SLOTS      = 16,
  parameter int unsigned SLOT_BYTES      = 4096,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned IW = $clog2(RING_SLOTS) + 1,
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  enable,
  input  logic [IW-1:0]         host_prod_idx,
  output logic [IW-1:0]         cons_idx,
  output logic [63:0]           dsc_byp_src_addr,
  output logic [63:0]           dsc_byp_dst_addr,
  output logic [27:0]           dsc_byp_len,
  output logic [15:0]           dsc_byp_ctl,
  output logic                  dsc_byp_load,
  input  logic                  dsc_byp_ready,
  input  logic [BEAT_BITS-1:0]  h2c_tdata,
  input  logic [BEAT_BYTES-1:0] h2c_tkeep,
  input  logic                  h2c_tlast,
  input  logic                  h2c_tvalid,
  output logic                  h2c_tready,
  output logic [BEAT_BITS-1:0]  RX_tdata,
  output logic [BEAT_BYTES-1:0] RX_tkeep,
  output logic                  RX_tlast,
  output logic                  RX_tvalid,
  input  logic                  RX_tready,
  output logic [OW-1:0]         outstanding,
  output logic                  err_overrun,
  output logic                  err_unexpected
);

  localparam int unsigned BEATS_PER_SLOT = SLOT_BYTES / BEAT_BYTES;
  localparam int unsigned BW             = $clog2(BEATS_PER_SLOT + 1);

  state_e        r_state;
  state_e        w_state_nxt;
  logic [IW-1:0] r_iss_idx;
  logic [IW-1:0] r_cons_idx;
  logic [OW-1:0] r_outstanding;
  logic [BW-1:0] r_beat_cnt;
  logic          r_err_overrun;
  logic          r_err_unexpected;
  logic [63:0]   r_src_addr;
  logic [63:0]   r_dst_addr;
  logic [27:0]   r_len;
  logic [15:0]   r_ctl;

  logic          w_pending;
  logic          w_can_issue;
  logic          w_start;
  logic          w_load;
  logic          w_accept;
  logic          w_beat;
  logic          w_complete;
  logic          w_overrun_beat;
  logic [63:0]   w_slot_addr;

  assign RX_tdata   = h2c_tdata;
  assign RX_tkeep   = h2c_tkeep;
  assign RX_tlast   = h2c_tlast;
  assign RX_tvalid  = h2c_tvalid;
  assign h2c_tready = RX_tready;

  assign w_pending   = (host_prod_idx != r_iss_idx);
  assign w_can_issue = enable && w_pending && (r_outstanding < OW'(MAX_OUTSTANDING));
  assign w_accept    = w_load && dsc_byp_ready;
  assign w_slot_addr = RING_BASE + 64'(r_iss_idx[IW-2:0]) * 64'(SLOT_BYTES);

  // A tlast with nothing outstanding is an error beat, not a completion.
  assign w_beat         = h2c_tvalid && RX_tready;
  assign w_complete     = w_beat && h2c_tlast && (r_outstanding != '0);
  assign w_overrun_beat = w_beat && !h2c_tlast && (r_beat_cnt >= BW'(BEATS_PER_SLOT - 1));

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_can_issue) begin
          w_state_nxt = ST_ISSUE;
          w_start     = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_load = 1'b1;
        if (dsc_byp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_src_addr <= '0;
      r_dst_addr <= '0;
      r_len      <= '0;
      r_ctl      <= '0;
    end else if (w_start) begin
      r_src_addr <= w_slot_addr;
      r_dst_addr <= '0;
      r_len      <= 28'(SLOT_BYTES);
      r_ctl      <= CTL_EOP;
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_iss_idx     <= '0;
      r_cons_idx    <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_accept)   r_iss_idx  <= r_iss_idx + IW'(1);
      if (w_complete) r_cons_idx <= r_cons_idx + IW'(1);
      case ({w_accept, w_complete})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // The beat counter saturates at one slot so a runaway transfer cannot wrap it.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_beat_cnt       <= '0;
      r_err_overrun    <= 1'b0;
      r_err_unexpected <= 1'b0;
    end else begin
      if (w_beat) begin
        if (h2c_tlast)                              r_beat_cnt <= '0;
        else if (r_beat_cnt != BW'(BEATS_PER_SLOT)) r_beat_cnt <= r_beat_cnt + BW'(1);
      end
      if (w_overrun_beat)                      r_err_overrun    <= 1'b1;
      if (w_beat && (r_outstanding == '0))     r_err_unexpected <= 1'b1;
    end
  end

  assign dsc_byp_load     = w_load;
  assign dsc_byp_src_addr = r_src_addr;
  assign dsc_byp_dst_addr = r_dst_addr;
  assign dsc_byp_len      = r_len;
  assign dsc_byp_ctl      = r_ctl;
  assign cons_idx         = r_cons_idx;
  assign outstanding      = r_outstanding;
  assign err_overrun      = r_err_overrun;
  assign err_unexpected   = r_err_unexpected;

endmodule

// File: doc/h2c_dsc_bypass_ctrl.md
H2C_DSC_BYPASS_CTRL -- requirements
Module: h2c_dsc_bypass_ctrl

Interface
REQ-001 SHALL have parameter RING_BASE, default 64'h100000000, giving the host address of ring slot 0.
REQ-002 SHALL have parameter RING_SLOTS, default 16, giving the number of slots (power of two, 2..256).
REQ-003 SHALL have parameter SLOT_BYTES, default 4096, giving the bytes per slot (multiple of 32).
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, giving the maximum number of descriptors accepted but not yet completed.
REQ-005 SHALL have port clk, input, 1 bit: the single clock (the XDMA axi_aclk domain).
REQ-006 SHALL have port sys_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port enable, input, 1 bit: permits new descriptor issue.
REQ-008 SHALL have port host_prod_idx, input, IW=log2(RING_SLOTS)+1 bits: host producer index, where the MSB is the wrap bit.
REQ-009 SHALL have port cons_idx, output, IW bits: slots fully received.
REQ-010 SHALL have ports dsc_byp_src_addr (output, 64), dsc_byp_dst_addr (output, 64), dsc_byp_len (output, 28) and dsc_byp_ctl (output, 16): the descriptor fields.
REQ-011 SHALL have port dsc_byp_load, output, 1 bit, and port dsc_byp_ready, input, 1 bit: the descriptor handshake.
REQ-012 SHALL have ports h2c_tdata (input, 256), h2c_tkeep (input, 32), h2c_tlast (input, 1), h2c_tvalid (input, 1) and h2c_tready (output, 1): the stream from XDMA.
REQ-013 SHALL have ports RX_tdata (output, 256), RX_tkeep (output, 32), RX_tlast (output, 1), RX_tvalid (output, 1) and RX_tready (input, 1): the stream to the user logic.
REQ-014 SHALL have ports outstanding (output, log2(MAX_OUTSTANDING)+1 bits), err_overrun (output, 1) and err_unexpected (output, 1): status.

Function
REQ-015 SHALL keep an issue index iss_idx (IW bits); a slot is pending when host_prod_idx != iss_idx.
REQ-016 SHALL implement the FSM states IDLE and ISSUE.
REQ-017 SHALL move IDLE->ISSUE when enable is high, a slot is pending and outstanding < MAX_OUTSTANDING; in that transition it registers the descriptor fields.
REQ-018 SHALL register the descriptor fields as: src = RING_BASE + iss_idx[IW-2:0]*SLOT_BYTES; dst = 0; len = SLOT_BYTES; ctl = 16'h0010 (EOP).
REQ-019 SHALL hold dsc_byp_load high for the whole of ISSUE and keep the fields stable until acceptance.
REQ-020 SHALL treat a descriptor as accepted on a cycle where dsc_byp_load and dsc_byp_ready are both high; on acceptance: iss_idx+1 (modulo 2*RING_SLOTS), outstanding+1, and the FSM returns to IDLE.
REQ-021 SHALL take at least 2 cycles between consecutive acceptances, because IDLE is always visited between them.
REQ-022 SHALL complete any ISSUE already entered when enable falls; no new ISSUE is entered while enable is low.
REQ-023 SHALL pass the stream through combinationally: RX_t* = h2c_t*, and h2c_tready = RX_tready.
REQ-024 SHALL treat a beat as transferred when h2c_tvalid and RX_tready are both high.
REQ-025 SHALL count transferred beats per transfer in beat_cnt.
REQ-026 SHALL, on a transferred beat with tlast while outstanding > 0: outstanding-1, cons_idx+1 (with wrap), and beat_cnt cleared.
REQ-027 SHALL, when an acceptance and a completion occur in the same cycle, leave outstanding unchanged and still advance both indices.
REQ-028 SHALL set err_overrun, sticky, when beat_cnt reaches SLOT_BYTES/32 without tlast; the beat still passes.
REQ-029 SHALL set err_unexpected, sticky, on a transferred beat while outstanding == 0; the beat still passes and cons_idx and outstanding are unchanged.
REQ-030 SHALL never exceed MAX_OUTSTANDING or underflow 0 in outstanding.
REQ-031 SHALL make host_prod_idx - cons_idx <= RING_SLOTS the host's responsibility, with no check in the block.

Reset
REQ-032 SHALL, on sys_rst asserted, immediately: FSM=IDLE, dsc_byp_load=0, all descriptor fields=0, iss_idx=0, cons_idx=0, outstanding=0, beat_cnt=0, err_overrun=0, err_unexpected=0.
REQ-033 SHALL abandon any ISSUE in progress on reset mid-operation, with no acceptance counted.
REQ-034 SHALL leave the stream pass-through unaffected by reset.

Structure
REQ-035 SHALL place the EOP ctl constant (16'h0010), the 256-bit beat width and the FSM state encoding in a shared package, h2c_dsc_pkg.
REQ-036 SHALL be flat, with no sub-module.

Verification
REQ-037 SHALL cover: reset, then enable=1 and host_prod_idx=1 with ready=1 -> one load pulse with src=64'h100000000, len=28'h1000, ctl=16'h0010; after 128 beats with tlast on the last: cons_idx=1, outstanding=0.
REQ-038 SHALL cover: host_prod_idx=6 with ready=1 and the stream stalled -> exactly 4 acceptances, outstanding=4, load stays low; one tlast completion -> a 5th descriptor issues with src=64'h100004000.
REQ-039 SHALL cover: prod stepped to 17 -> issue src addresses wrap from slot 15 (64'h10000F000) to slot 0; iss_idx goes 5'h0F->5'h10.
REQ-040 SHALL cover: ready held 0 for 10 cycles during ISSUE -> load stays high with stable fields, one acceptance when ready rises; acceptance and tlast in the same cycle -> outstanding unchanged.
REQ-041 SHALL cover: 129 beats without tlast -> err_overrun=1 at beat 128; a beat with outstanding=0 -> err_unexpected=1, data still on RX.
REQ-042 SHALL cover: sys_rst pulsed while load=1 -> load=0 and outstanding=0 within the same cycle, no acceptance counted.
